// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: request channel (valid/ready)
// and an in-order response channel with no backpressure.
interface if_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    // The fetch stage issues requests and consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    // The instruction memory accepts requests and returns responses.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, 2-entry address queue,
// 2-entry fetch buffer with bypass into IF/ID, and branch flush with response dropping.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    if_stage_if.master  imem,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    logic [31:0] fetch_pc;

    // In-order queue of addresses for live (not-yet-dropped) requests.
    logic [31:0] aq_addr [2];
    logic        aq_head;
    logic [1:0]  aq_count;

    logic [31:0] fb_pc   [2];
    logic [31:0] fb_inst [2];
    logic        fb_head;
    logic [1:0]  fb_count;

    logic [1:0]  drop_cnt;

    logic [1:0]  outstanding;
    logic [2:0]  credit;
    logic        req_fire;
    logic        resp_drop;
    logic        resp_live;
    logic [31:0] resp_pc;
    logic        fb_pop;
    logic        bypass;
    logic        fb_push;
    logic        aq_tail;
    logic        fb_tail;
    logic [1:0]  drop_next;

    // Dropped requests are still in flight, so they consume credit like live ones.
    assign outstanding = aq_count + drop_cnt;
    assign credit      = {1'b0, outstanding} + {1'b0, fb_count};

    assign imem.imem_req_valid = rst && !take_branch && (credit < 3'd2);
    assign imem.imem_req_addr  = fetch_pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    // A response with an empty address queue has no owner (e.g. issued before reset).
    assign resp_drop = imem.imem_resp_valid && (drop_cnt != 2'd0);
    assign resp_live = imem.imem_resp_valid && (drop_cnt == 2'd0) && (aq_count != 2'd0);
    assign resp_pc   = aq_addr[aq_head];

    assign fb_pop  = !stall && (fb_count != 2'd0);
    assign bypass  = !stall && (fb_count == 2'd0) && resp_live;
    assign fb_push = resp_live && !bypass;

    // Tail is head+count mod 2; with a full buffer it aliases the slot being popped.
    assign aq_tail = aq_head ^ aq_count[0];
    assign fb_tail = fb_head ^ fb_count[0];

    assign drop_next = (imem.imem_resp_valid && (outstanding != 2'd0))
                     ? outstanding - 2'd1 : outstanding;

    // NOTE: non-blocking assignments throughout, so every right-hand side reads pre-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (take_branch) begin
            fetch_pc <= {branch_target[31:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // NOTE: the small queue/buffer payload arrays are reset as well so post-reset state is fully defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                aq_addr[i] <= '0;
            end
            aq_head  <= 1'b0;
            aq_count <= 2'd0;
            drop_cnt <= 2'd0;
        end else if (take_branch) begin
            aq_head  <= 1'b0;
            aq_count <= 2'd0;
            drop_cnt <= drop_next;
        end else begin
            if (req_fire) begin
                aq_addr[aq_tail] <= fetch_pc;
            end
            aq_head  <= aq_head ^ resp_live;
            aq_count <= aq_count + {1'b0, req_fire} - {1'b0, resp_live};
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fb_pc[i]   <= '0;
                fb_inst[i] <= '0;
            end
            fb_head  <= 1'b0;
            fb_count <= 2'd0;
        end else if (take_branch) begin
            fb_head  <= 1'b0;
            fb_count <= 2'd0;
        end else begin
            if (fb_push) begin
                fb_pc[fb_tail]   <= resp_pc;
                fb_inst[fb_tail] <= imem.imem_resp_data;
            end
            fb_head  <= fb_head ^ fb_pop;
            fb_count <= fb_count + {1'b0, fb_push} - {1'b0, fb_pop};
        end
    end

    // IF/ID register: buffered instructions are older than the arriving response, so they go first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_IR         <= NOP_INST;
            if_id_PC         <= RESET_PC;
            if_id_valid_inst <= 1'b0;
        end else if (take_branch) begin
            if_id_IR         <= NOP_INST;
            if_id_valid_inst <= 1'b0;
        end else if (!stall) begin
            if (fb_count != 2'd0) begin
                if_id_IR         <= fb_inst[fb_head];
                if_id_PC         <= fb_pc[fb_head];
                if_id_valid_inst <= 1'b1;
            end else if (resp_live) begin
                if_id_IR         <= imem.imem_resp_data;
                if_id_PC         <= resp_pc;
                if_id_valid_inst <= 1'b1;
            end else begin
                if_id_IR         <= NOP_INST;
                if_id_valid_inst <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an in-order memory model returning the request
// address as data, with per-request latency chosen by the stimulus.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        take_branch;
    logic [31:0] branch_target;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    if_stage_if bus ();

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .take_branch      (take_branch),
        .branch_target    (branch_target),
        .imem             (bus),
        .if_id_IR         (if_id_IR),
        .if_id_PC         (if_id_PC),
        .if_id_valid_inst (if_id_valid_inst)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc;
    int    lat;
    int    n_checks;
    int    n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                              input logic valid);
        check({tag, ".pc"}, if_id_PC, pc);
        check({tag, ".ir"}, if_id_IR, ir);
        check({tag, ".valid"}, {31'd0, if_id_valid_inst}, {31'd0, valid});
    endtask

    task automatic check_nop(input string tag);
        check({tag, ".ir"}, if_id_IR, NOP);
        check({tag, ".valid"}, {31'd0, if_id_valid_inst}, 32'd0);
    endtask

    task automatic check_req(input string tag, input logic valid, input logic [31:0] addr);
        check({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, valid});
        check({tag, ".req_addr"}, bus.imem_req_addr, addr);
    endtask

    // One clock: capture a handshake just before the edge, then present the next due response.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        pend_t       e;
        #1;
        acc      = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
        @(posedge clk);
        cyc++;
        if (acc) begin
            e.addr = acc_addr;
            e.due  = cyc + lat - 1;
            pend.push_back(e);
        end
        #1;
        bus.imem_resp_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = pend[0].addr;
            void'(pend.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        cyc      = 0;
        lat      = 1;
        rst           = 1'b0;
        stall         = 1'b0;
        take_branch   = 1'b0;
        branch_target = 32'd0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;

        repeat (2) @(negedge clk);
        check_ifid("reset", 32'h0, NOP, 1'b0);
        check_req("reset", 1'b0, 32'h0);

        // Back-to-back fetch with 1-cycle memory
        rst = 1'b1;
        #1;
        check_req("release", 1'b1, 32'h0);
        tick();
        check_nop("first_edge");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_ifid("stream", 32'(4 * k), 32'(4 * k), 1'b1);
        end

        // Stall for 3 cycles while IF/ID holds 0x8
        stall = 1'b1;
        tick();
        check_ifid("stall1", 32'h8, 32'h8, 1'b1);
        check_req("stall1", 1'b0, 32'h14);
        tick();
        check_ifid("stall2", 32'h8, 32'h8, 1'b1);
        tick();
        check_ifid("stall3", 32'h8, 32'h8, 1'b1);
        check_req("stall3", 1'b0, 32'h14);
        stall = 1'b0;
        tick();
        check_ifid("unstall_c", 32'hC, 32'hC, 1'b1);
        check_req("unstall_c", 1'b1, 32'h14);
        tick();
        check_ifid("unstall_10", 32'h10, 32'h10, 1'b1);
        tick();
        check_ifid("unstall_14", 32'h14, 32'h14, 1'b1);

        // Redirect with two requests outstanding (3-cycle memory); target low bits ignored
        lat = 3;
        tick();
        check_ifid("slow_18", 32'h18, 32'h18, 1'b1);
        tick();
        check_nop("slow_gap");
        check_req("two_out", 1'b0, 32'h24);
        take_branch   = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        take_branch = 1'b0;
        lat = 1;
        check_nop("redirect");
        #1;
        check_req("redirect", 1'b0, 32'h100);
        tick();
        check_nop("drop1");
        check_req("drop1", 1'b1, 32'h100);
        tick();
        check_nop("drop2");
        tick();
        check_ifid("target", 32'h100, 32'h100, 1'b1);
        tick();
        check_ifid("target_4", 32'h104, 32'h104, 1'b1);

        // Redirect and stall together: redirect wins
        stall         = 1'b1;
        take_branch   = 1'b1;
        branch_target = 32'h200;
        tick();
        check_nop("br_stall");
        stall       = 1'b0;
        take_branch = 1'b0;
        #1;
        check_req("br_stall", 1'b1, 32'h200);
        tick();
        check_nop("br_stall_gap");
        tick();
        check_ifid("br_stall_tgt", 32'h200, 32'h200, 1'b1);

        // Memory not ready for 5 cycles
        bus.imem_req_ready = 1'b0;
        tick();
        check_ifid("nrdy_drain", 32'h204, 32'h204, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_nop("nrdy_idle");
        end
        check_req("nrdy_frozen", 1'b1, 32'h208);
        bus.imem_req_ready = 1'b1;
        tick();
        check_nop("rdy_gap");
        tick();
        check_ifid("rdy_208", 32'h208, 32'h208, 1'b1);
        tick();
        check_ifid("rdy_20c", 32'h20C, 32'h20C, 1'b1);

        // Reset with one request outstanding; its late response must be ignored
        bus.imem_req_ready = 1'b0;
        tick();
        check_ifid("pre_rst", 32'h210, 32'h210, 1'b1);
        bus.imem_req_ready = 1'b1;
        lat = 2;
        tick();
        check_req("pre_rst", 1'b1, 32'h218);
        rst = 1'b0;
        #1;
        check_ifid("async_rst", 32'h0, NOP, 1'b0);
        check_req("async_rst", 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        lat = 1;
        #1;
        check_req("restart", 1'b1, 32'h0);
        check("late_resp_present", {31'd0, bus.imem_resp_valid}, 32'd1);
        tick();
        check_ifid("late_ignored", 32'h0, NOP, 1'b0);
        tick();
        check_ifid("restart_0", 32'h0, 32'h0, 1'b1);
        tick();
        check_ifid("restart_4", 32'h4, 32'h4, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
